// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam int unsigned REG_IDX_W_DEFAULT = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN_DEFAULT-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic op_signed_a(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Lane-wise conditional two's-complement negate: magnitude extraction on the way in,
// sign correction on the way out.
module muldiv_sign_fix #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 1
) (
  input  logic [N-1:0][W-1:0] val,
  input  logic [N-1:0]        neg,
  output logic [N-1:0][W-1:0] res
);

  always_comb begin
    res = '0;
    for (int i = 0; i < int'(N); i++) begin
      res[i] = neg[i] ? (~val[i] + W'(1)) : val[i];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned REG_IDX_W = REG_IDX_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      result,
  output logic [REG_IDX_W-1:0] wr_idx,
  output logic                 wr_en
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e               state, state_nxt;
  logic [2:0]           op_q, op_nxt;
  logic                 neg_q, neg_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [XLEN-1:0]      acc_q, acc_nxt;
  logic [XLEN-1:0]      lo_q, lo_nxt;
  logic [XLEN-1:0]      opnd_q, opnd_nxt;
  logic                 busy_nxt, done_nxt, wr_en_nxt;
  logic [XLEN-1:0]      result_nxt;
  logic [REG_IDX_W-1:0] wr_idx_nxt;

  logic                 neg_a_in, neg_b_in, neg_res_in;
  logic [1:0][XLEN-1:0] mag_in;
  logic                 div_zero, div_ovf, special, fast_mul;
  logic [XLEN-1:0]      special_res;
  logic [XLEN:0]        mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [XLEN-1:0]      acc_step, lo_step;
  logic [PW-1:0]        raw_iter, fix_raw, fix_res;
  logic                 fix_neg;
  logic [2:0]           fix_op;
  logic [XLEN-1:0]      fix_sel;

  // Operand conditioning: magnitudes plus the sign the final result must carry
  assign neg_a_in   = op_signed_a(funct3) & op_a[XLEN-1];
  assign neg_b_in   = op_signed_b(funct3) & op_b[XLEN-1];
  assign neg_res_in = (funct3 == F3_REM) ? neg_a_in : (neg_a_in ^ neg_b_in);

  muldiv_sign_fix #(.W(XLEN), .N(2)) u_in_fix (
    .val ({op_a, op_b}),
    .neg ({neg_a_in, neg_b_in}),
    .res (mag_in)
  );

  assign div_zero    = op_is_div(funct3) && (op_b == '0);
  assign div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == INT_MIN) && (op_b == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (funct3[1] ? op_a : XLEN'(DIV_BY_ZERO_Q))
                                : (funct3[1] ? '0 : INT_MIN);

  // One iteration: shift-add for multiply, restoring subtract for divide
  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[XLEN];
  assign acc_step  = op_q[2] ? (div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]) : mul_sum[XLEN:1];
  assign lo_step   = op_q[2] ? {lo_q[XLEN-2:0], div_ge} : {mul_sum[0], lo_q[XLEN-1:1]};
  assign raw_iter  = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? acc_step : lo_step)} : {acc_step, lo_step};

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_in[1]} * {{XLEN{1'b0}}, mag_in[0]};
  assign fast_mul  = ~funct3[2];
  assign fix_raw   = (state == ST_CALC) ? raw_iter : fast_prod;
  assign fix_neg   = (state == ST_CALC) ? neg_q : neg_res_in;
  assign fix_op    = (state == ST_CALC) ? op_q : funct3;
`else
  assign fast_mul  = 1'b0;
  assign fix_raw   = raw_iter;
  assign fix_neg   = neg_q;
  assign fix_op    = op_q;
`endif

  muldiv_sign_fix #(.W(PW), .N(1)) u_out_fix (
    .val (fix_raw),
    .neg (fix_neg),
    .res (fix_res)
  );

  // High-half ops take the upper word of the corrected product
  assign fix_sel = (!fix_op[2] && (fix_op != F3_MUL)) ? fix_res[PW-1:XLEN] : fix_res[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    neg_nxt    = neg_q;
    cnt_nxt    = cnt_q;
    acc_nxt    = acc_q;
    lo_nxt     = lo_q;
    opnd_nxt   = opnd_q;
    result_nxt = result;
    wr_idx_nxt = wr_idx;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (start) begin
          op_nxt     = funct3;
          neg_nxt    = neg_res_in;
          cnt_nxt    = '0;
          acc_nxt    = '0;
          lo_nxt     = mag_in[1];
          opnd_nxt   = mag_in[0];
          wr_idx_nxt = rd_idx;
          if (special) begin
            state_nxt  = ST_DONE;
            result_nxt = special_res;
          end else if (fast_mul) begin
            state_nxt  = ST_DONE;
            result_nxt = fix_sel;
          end else begin
            state_nxt  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        acc_nxt = acc_step;
        lo_nxt  = lo_step;
        if (cnt_q == CNT_LAST) begin
          state_nxt  = ST_DONE;
          result_nxt = fix_sel;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt  = (state_nxt == ST_CALC);
    done_nxt  = (state_nxt == ST_DONE);
    wr_en_nxt = done_nxt && (wr_idx_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      wr_idx <= '0;
      wr_en  <= 1'b0;
    end else begin
      op_q   <= op_nxt;
      neg_q  <= neg_nxt;
      cnt_q  <= cnt_nxt;
      acc_q  <= acc_nxt;
      lo_q   <= lo_nxt;
      opnd_q <= opnd_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
      wr_idx <= wr_idx_nxt;
      wr_en  <= wr_en_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a reference model,
// and hand-written reset / back-to-back sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XW = 32;
  localparam int unsigned RW = 5;
  localparam int CALC_LAT = 33;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    funct3;
  logic [XW-1:0] op_a, op_b;
  logic [RW-1:0] rd_idx;
  logic          busy, done, wr_en;
  logic [XW-1:0] result;
  logic [RW-1:0] wr_idx;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XW), .REG_IDX_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_idx(rd_idx), .busy(busy), .done(done), .result(result), .wr_idx(wr_idx), .wr_en(wr_en)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[NV];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sxa, sxb, ua, ub, p;
    logic signed [31:0] as_, bs_;
    sxa = {{32{a[31]}}, a};
    sxb = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    as_ = a;
    bs_ = b;
    p   = '0;
    case (f)
      F3_MUL:    begin p = ua * ub;   return p[31:0];  end
      F3_MULH:   begin p = sxa * sxb; return p[63:32]; end
      F3_MULHSU: begin p = sxa * ub;  return p[63:32]; end
      F3_MULHU:  begin p = ua * ub;   return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(as_ / bs_);
      end
      F3_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(as_ % bs_);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return CALC_LAT;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT is presenting
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!done) check("wr_en_outside_done", {31'd0, wr_en}, 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %h wr_idx %0d at cycle %0d, expected no done", result, wr_idx, cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("op%0d_result", e.id), result, e.res);
        check($sformatf("op%0d_wr_idx", e.id), 32'(wr_idx), 32'(e.rd));
        check($sformatf("op%0d_wr_en", e.id), {31'd0, wr_en}, {31'd0, (e.rd != 5'd0)});
        check($sformatf("op%0d_latency", e.id), 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input bit push, input int id);
    exp_t e;
    funct3 = f; op_a = a; op_b = b; rd_idx = rd; start = 1'b1;
    if (push) begin
      e.res = exp_res; e.rd = rd; e.lat = exp_lat(f, a, b); e.acc = cyc; e.id = id;
      sb.push_back(e);
    end
    tick();
    start  = 1'b0;
    op_a   = $urandom();
    op_b   = $urandom();
    rd_idx = RW'($urandom());
    funct3 = 3'($urandom());
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d ops pending after %0d cycles, expected 0", sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors so far", checks, errors);
    $fatal(1);
  end

  initial begin
    int nb;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    tbl = '{
      '{F3_MUL,    32'd7,         32'd6,         5'd3,  32'd42},
      '{F3_MULH,   32'hFFFF_FFFF, 32'd2,         5'd5,  32'hFFFF_FFFF},
      '{F3_MULHU,  32'hFFFF_FFFF, 32'd2,         5'd6,  32'h0000_0001},
      '{F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'hFFFF_FFFF},
      '{F3_MULHSU, 32'd2,         32'hFFFF_FFFF, 5'd8,  32'h0000_0001},
      '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000},
      '{F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001},
      '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE},
      '{F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD},
      '{F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF},
      '{F3_DIV,    32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD},
      '{F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd15, 32'h0000_0001},
      '{F3_DIVU,   32'hFFFF_FFFF, 32'd10,        5'd16, 32'h1999_9999},
      '{F3_REMU,   32'hFFFF_FFFF, 32'd10,        5'd17, 32'h0000_0005},
      '{F3_DIVU,   32'd100,       32'd0,         5'd18, 32'hFFFF_FFFF},
      '{F3_REMU,   32'd100,       32'd0,         5'd19, 32'h0000_0064},
      '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000},
      '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000},
      '{F3_DIV,    32'd5,         32'd0,         5'd22, 32'hFFFF_FFFF},
      '{F3_MUL,    32'd3,         32'd4,         5'd0,  32'd12},
      '{F3_REM,    32'hFFFF_FFF9, 32'd0,         5'd1,  32'hFFFF_FFF9}
    };

    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; rd_idx = '0;
    tick();
    tick();
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_result", result,         32'd0);
    check("reset_wr_idx", 32'(wr_idx),    32'd0);
    check("reset_wr_en",  {31'd0, wr_en}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, 1'b1, i);
      wait_drain(60);
    end

    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = (i % 4 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom());
      drive(rf, ra, rb, RW'($urandom()), ref_result(rf, ra, rb), 1'b1, 50 + i);
      wait_drain(60);
    end

    // MUL 7x6: busy window length and result/wr_idx hold after done
    drive(F3_MUL, 32'd7, 32'd6, 5'd3, 32'd42, 1'b1, 100);
    nb = busy ? 1 : 0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      tick();
      if (busy) nb++;
    end
`ifdef MULDIV_FAST_MUL_EN
    check("mul_busy_cycles", 32'(nb), 32'd0);
`else
    check("mul_busy_cycles", 32'(nb), 32'd32);
`endif
    wait_drain(1);
    tick();
    check("hold_result", result,         32'd42);
    check("hold_wr_idx", 32'(wr_idx),    32'd3);
    check("hold_done",   {31'd0, done},  32'd0);

    // Reset in cycle 10 of a DIV aborts it with no done pulse
    drive(F3_DIV, 32'd1000, 32'd3, 5'd4, 32'd0, 1'b0, 101);
    repeat (9) tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("abort_busy",   {31'd0, busy},  32'd0);
    check("abort_done",   {31'd0, done},  32'd0);
    check("abort_result", result,         32'd0);
    check("abort_wr_idx", 32'(wr_idx),    32'd0);
    check("abort_wr_en",  {31'd0, wr_en}, 32'd0);
    rst = 1'b0;
    repeat (45) tick();

    // Back-to-back: second op accepted in DONE, start pulses in CALC ignored
    drive(F3_MUL, 32'd5, 32'd5, 5'd0, 32'd25, 1'b1, 200);
    for (int i = 0; i < 60 && !done; i++) tick();
    check("b2b_first_done", {31'd0, done}, 32'd1);
    drive(F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1, 201);
    check("b2b_busy_next", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9; rd_idx = 5'd7; start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_drain(60);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit sitting directly downstream of the register file.
- Consumes the two register-read operands plus a decoded funct3 and destination index.
- Computes over multiple cycles; returns result, write index and write enable straight into the register-file write port (Data_in / Wr_idx / En).
- Decode stalls on busy.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- REG_IDX_W, 5, register index width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when unit is idle or done.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (Reg_1).
- op_b  input  XLEN  rs2 value (Reg_2).
- rd_idx  input  REG_IDX_W  destination register index.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  computed value, held until next accepted start.
- wr_idx  output  REG_IDX_W  latched rd_idx.
- wr_en  output  1  done AND wr_idx != 0.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE;
  - busy=0, done=0, result=0, wr_idx=0, wr_en=0;
  - internal accumulators/counter cleared.
- Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 latches funct3, rd_idx and operands → CALC (or DONE for special cases).
  - CALC: busy=1; iteration counter runs 0..XLEN-1; at count XLEN-1 apply sign fix-up and load result → DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted (back-to-back) → CALC; else → IDLE.
- start while busy=1 is ignored; no queueing.
- Latency: start sampled at edge 0 → busy cycles 1..XLEN → done high in cycle XLEN+1.
- Operand capture happens at the accepting edge. op_a/op_b may change afterwards without effect.
- Signed handling:
  - At start, take magnitudes per op signedness: MULH both signed; MULHSU op_a signed, op_b unsigned; DIV/REM both signed.
  - Record the result sign:
    - product sign = sa XOR sb;
    - quotient sign = sa XOR sb;
    - remainder sign = sign of dividend.
- Multiply: shift-add over a 2*XLEN product.
  - MUL returns low XLEN bits.
  - MULH/MULHSU/MULHU return high XLEN bits of the sign-corrected 2*XLEN product.
- Divide: restoring, one quotient bit per cycle, remainder register XLEN+1 bits.
- Special cases skip CALC: IDLE/DONE → DONE directly, done in cycle 1.
  - op_b == 0: DIV/DIVU result = all ones; REM/REMU result = op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- rd_idx == 0: computation runs normally, done pulses, wr_en stays 0.
- result/wr_idx are stable from done until the next accepted start. wr_en is never high outside done.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN product and go IDLE → DONE.
  - Done is in cycle 1; busy is never asserted for multiplies.
  - Divide is unchanged.
- Undefined:
  - All multiplies are iterative with XLEN+1 latency as above.
  - No wide multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 op encodings as named constants;
  - FSM state encoding (IDLE, CALC, DONE);
  - XLEN default;
  - DIV_BY_ZERO_Q constant (all ones).
- One sub-module is natural: muldiv_sign_fix.
  - Combinational magnitude/negate logic for operand conditioning and result correction.
  - Instantiated once for inputs and once for the output.

Test Plan:
- Reset asserted mid-CALC (cycle 10 of a DIV) → next cycle busy=0, done=0, result=0; no done pulse afterwards.
- MUL op_a=7, op_b=6, rd_idx=3 → done in cycle 33 with result=42, wr_idx=3, wr_en=1; busy high cycles 1..32.
- MULH op_a=0xFFFFFFFF (−1), op_b=0x00000002 → result=0xFFFFFFFF; MULHU same operands → result=0x00000001.
- DIV op_a=−7 (0xFFFFFFF9), op_b=2 → result=0xFFFFFFFD (−3); REM same operands → result=0xFFFFFFFF (−1).
- DIVU op_a=100, op_b=0 → done in cycle 1, result=0xFFFFFFFF; REM op_a=0x80000000, op_b=0xFFFFFFFF → done in cycle 1, result=0.
- Back-to-back: start held high in DONE of a MUL (rd_idx=0) → that done has wr_en=0; second op accepted the same edge, busy next cycle; start pulses during CALC are ignored.
- With MULDIV_FAST_MUL_EN defined: MUL 7×6 → done in cycle 1 with result=42, busy never asserted.
